// File: rtl/ik_stage_sequencer.sv
// IK stage sequencer: steps the eight IK datapath stages with one-hot clock enables (reach reject path under IK_REACH_CHECK_EN).
// Latency: sum(LAT_*) stage cycles after the start edge, then one DONE cycle carrying dataReady.
// Backpressure: none; enable is sampled only in IDLE and abort cancels any active sequence at the next edge.
module ik_stage_sequencer #(
    parameter int LAT_T2D   = 6,
    parameter int LAT_COS   = 14,
    parameter int LAT_SIN   = 30,
    parameter int LAT_K1    = 11,
    parameter int LAT_K2    = 11,
    parameter int LAT_GAMMA = 11,
    parameter int LAT_ATAN  = 40,
    parameter int LAT_TH    = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       abort,
    input  logic       cos_out_of_range,
    output logic [7:0] stage_en,
    output logic       stage_last,
    output logic [3:0] stage_id,
    output logic       busy,
    output logic       dataReady,
    output logic       unreachable
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T2D   = 4'd1,
        S_COS   = 4'd2,
        S_SIN   = 4'd3,
        S_K1    = 4'd4,
        S_K2    = 4'd5,
        S_GAMMA = 4'd6,
        S_ATAN  = 4'd7,
        S_TH    = 4'd8,
        S_DONE  = 4'd9,
        S_ERR   = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_succ;
    logic [7:0] r_cnt;
    logic [7:0] w_next_cnt;
    logic       w_in_stage;
    logic       w_cnt_zero;
    logic       w_reject;

    // Counter reload value for a stage: it counts LAT-1 down to 0.
    function automatic logic [7:0] f_load(input state_t s);
        case (s)
            S_T2D:   f_load = 8'(LAT_T2D - 1);
            S_COS:   f_load = 8'(LAT_COS - 1);
            S_SIN:   f_load = 8'(LAT_SIN - 1);
            S_K1:    f_load = 8'(LAT_K1 - 1);
            S_K2:    f_load = 8'(LAT_K2 - 1);
            S_GAMMA: f_load = 8'(LAT_GAMMA - 1);
            S_ATAN:  f_load = 8'(LAT_ATAN - 1);
            S_TH:    f_load = 8'(LAT_TH - 1);
            default: f_load = 8'd0;
        endcase
    endfunction

    assign w_in_stage = (r_state >= S_T2D) && (r_state <= S_TH);
    assign w_cnt_zero = (r_cnt == 8'd0);
    assign w_succ     = state_t'(r_state + 4'd1);

`ifdef IK_REACH_CHECK_EN
    assign w_reject = (r_state == S_COS) && w_cnt_zero && cos_out_of_range;
`else
    logic w_unused_cos;
    assign w_unused_cos = cos_out_of_range;
    assign w_reject     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        if (abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
            w_next_cnt   = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && !abort) begin
                        w_next_state = S_T2D;
                        w_next_cnt   = f_load(S_T2D);
                    end
                end
                S_DONE, S_ERR: begin
                    w_next_state = S_IDLE;
                    w_next_cnt   = 8'd0;
                end
                default: begin
                    if (!w_in_stage) begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = 8'd0;
                    end else if (!w_cnt_zero) begin
                        w_next_cnt = r_cnt - 8'd1;
                    end else if (w_reject) begin
                        w_next_state = S_ERR;
                        w_next_cnt   = 8'd0;
                    end else begin
                        // TH's successor is DONE, whose reload value is zero.
                        w_next_state = w_succ;
                        w_next_cnt   = f_load(w_succ);
                    end
                end
            endcase
        end
    end

    always_comb begin
        stage_en = 8'd0;
        if (w_in_stage) begin
            stage_en[3'(r_state - 4'd1)] = 1'b1;
        end
    end

    assign stage_last = w_in_stage && w_cnt_zero;
    assign stage_id   = r_state;
    assign busy       = (r_state != S_IDLE);
    assign dataReady  = (r_state == S_DONE);

`ifdef IK_REACH_CHECK_EN
    assign unreachable = (r_state == S_ERR);
`else
    assign unreachable = 1'b0;
`endif

endmodule

// File: tb/tb_ik_stage_sequencer.sv
// Bench for ik_stage_sequencer: directed scenarios plus random enable/abort/cos traffic.
// Expected pulses are queued by a start-time reference model and popped by a negedge monitor.
// Stimulus changes 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ik_stage_sequencer;

    localparam int LAT[8] = '{6, 14, 30, 11, 11, 11, 40, 14};
    localparam int TOTAL  = 137;
    localparam int COS_LAST_OFF = 6 + 14 - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       abort;
    logic       cos_out_of_range;
    logic [7:0] stage_en;
    logic       stage_last;
    logic [3:0] stage_id;
    logic       busy;
    logic       dataReady;
    logic       unreachable;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int cyc;
        bit err;
    } exp_t;
    exp_t q[$];

    // Model: mode 0 idle, 1 running from m_start (first T2D cycle), 2 in the one-cycle reject.
    int m_mode  = 0;
    int m_start = 0;
    int cyc     = 0;

    ik_stage_sequencer #(
        .LAT_T2D(LAT[0]), .LAT_COS(LAT[1]), .LAT_SIN(LAT[2]), .LAT_K1(LAT[3]),
        .LAT_K2(LAT[4]), .LAT_GAMMA(LAT[5]), .LAT_ATAN(LAT[6]), .LAT_TH(LAT[7])
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .abort(abort),
        .cos_out_of_range(cos_out_of_range),
        .stage_en(stage_en),
        .stage_last(stage_last),
        .stage_id(stage_id),
        .busy(busy),
        .dataReady(dataReady),
        .unreachable(unreachable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Stage index (0..7) for an offset into a running sequence; 8 means past the last stage.
    function automatic int stage_of(input int o);
        int acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (o < acc + LAT[i]) return i;
            acc += LAT[i];
        end
        return 8;
    endfunction

    function automatic bit is_last(input int o);
        int acc = 0;
        for (int i = 0; i < 8; i++) begin
            acc += LAT[i];
            if (o == acc - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [15:0] expected_outputs();
        logic [15:0] v;
        int o;
        int s;
        v = 16'd0;
        if (m_mode == 1) begin
            o = cyc - m_start;
            s = stage_of(o);
            if (s < 8) begin
                // {stage_id, stage_en, stage_last, busy, dataReady, unreachable}
                v = {4'(s + 1), 8'(1 << s), is_last(o), 1'b1, 1'b0, 1'b0};
            end else begin
                v = {4'd9, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
            end
        end else if (m_mode == 2) begin
            v = {4'd10, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        end
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0;
            q.delete();
        end else begin
            if (m_mode != 0 && abort) begin
                if (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (enable && !abort) begin
                    m_mode  = 1;
                    m_start = cyc + 1;
                    q.push_back('{cyc + 1 + TOTAL, 1'b0});
                end
            end else if (m_mode == 2) begin
                m_mode = 0;
            end else if (cyc - m_start == TOTAL) begin
                m_mode = 0;
            end
`ifdef IK_REACH_CHECK_EN
            else if (cyc - m_start == COS_LAST_OFF && cos_out_of_range) begin
                void'(q.pop_back());
                q.push_back('{cyc + 1, 1'b1});
                m_mode = 2;
            end
`endif
            cyc++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        check("outputs", 32'({stage_id, stage_en, stage_last, busy, dataReady, unreachable}),
              32'(expected_outputs()));
        if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            check("missed_pulse", 32'(0), 32'(e.cyc));
        end
        if (dataReady || unreachable) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", 32'(cyc), 32'hFFFFFFFF);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_kind", 32'(unreachable), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] s);
        int n = 0;
        while (stage_id !== s && n < 400) begin
            tick();
            n++;
        end
        check("wait_stage_id", 32'(stage_id), 32'(s));
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        abort = 1'b0;
        cos_out_of_range = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'({stage_en, stage_last, stage_id, busy, dataReady, unreachable}), 32'd0);
        reset = 1'b1;

        // Single enable pulse after idle cycles.
        repeat (9) tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (150) tick();

        // Enable held high: back-to-back sequences.
        enable = 1'b1;
        repeat (3 * 139 + 5) tick();
        enable = 1'b0;
        repeat (150) tick();

        // Abort in the 5th SIN cycle.
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_state(4'd3);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 32'({stage_id, stage_en, busy}), 32'd0);
        repeat (3) tick();

        // Enable and abort together in IDLE.
        enable = 1'b1;
        abort  = 1'b1;
        repeat (5) tick();
        check("abort_wins_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        abort  = 1'b0;
        tick();

        // Reset mid-ATAN, then a fresh sequence.
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_state(4'd7);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("async_reset_outputs", 32'({stage_en, stage_last, stage_id, busy, dataReady, unreachable}), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (150) tick();

        // cos_out_of_range held high for a whole sequence.
        cos_out_of_range = 1'b1;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (150) tick();
        cos_out_of_range = 1'b0;

        // Random traffic.
        repeat (3000) begin
            enable           = ($urandom_range(0, 7) == 0);
            abort            = ($urandom_range(0, 255) == 0);
            cos_out_of_range = 1'($urandom_range(0, 1));
            tick();
        end
        enable = 1'b0;
        abort  = 1'b0;
        repeat (150) tick();

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ik_stage_sequencer.md
IK_STAGE_SEQUENCER -- requirements
Module: ik_stage_sequencer

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning), each legal in 1..255:
  LAT_T2D, 6, cycles for target-to-double conversion
  LAT_COS, 14, cycles for cos(th2) stage
  LAT_SIN, 30, cycles for sin(th2) stage
  LAT_K1, 11, cycles for k1 stage
  LAT_K2, 11, cycles for k2 stage
  LAT_GAMMA, 11, cycles for gamma stage
  LAT_ATAN, 40, cycles for atan(y,x) stage
  LAT_TH, 14, cycles for final theta stage
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  enable  in  1  start request, sampled in IDLE
  abort  in  1  synchronous cancel
  cos_out_of_range  in  1  datapath flag, |cos th2|>1 (used only with IK_REACH_CHECK_EN)
  stage_en  out  8  one-hot clk_en to datapath stages; bit0=T2D ... bit7=TH
  stage_last  out  1  high on final cycle of current stage
  stage_id  out  4  current state encoding
  busy  out  1  high in any state except IDLE
  dataReady  out  1  one-cycle pulse, th1/th2 valid
  unreachable  out  1  one-cycle pulse, target rejected (tied 0 without macro)

Function
REQ-003 SHALL implement states IDLE(0), T2D(1), COS(2), SIN(3), K1(4), K2(5), GAMMA(6), ATAN(7), TH(8), DONE(9), ERR(10); stage_id SHALL equal the state code.
REQ-004 In IDLE with enable=1 and abort=0 at edge k, SHALL enter T2D at k+1.
REQ-005 Each stage state SHALL last exactly its LAT_* cycles, then advance in the order of REQ-003; TH SHALL advance to DONE.
REQ-006 stage_en SHALL be one-hot on the current stage bit throughout that stage and all-zero in IDLE, DONE and ERR.
REQ-007 SHALL use an 8-bit down-counter loaded with LAT_*-1 on stage entry; stage_last=1 when counter=0 inside a stage state.
REQ-008 DONE SHALL last one cycle with dataReady=1 and then return to IDLE unconditionally; with the defaults, dataReady SHALL assert at k+138.
REQ-009 enable SHALL be ignored outside IDLE; minimum start-to-start period SHALL be sum(LAT_*)+2 cycles.
REQ-010 abort=1 in any state except IDLE SHALL force IDLE at the next edge, with stage_en=0 and no dataReady or unreachable pulse.
REQ-011 If abort and enable are both high in IDLE, abort SHALL win and the block SHALL remain in IDLE.
REQ-012 abort sampled in DONE SHALL NOT suppress the dataReady already asserted in that cycle.
REQ-013 ERR SHALL last one cycle with unreachable=1 and then return to IDLE.
REQ-014 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational input-to-output path.

Reset
REQ-015 reset low SHALL asynchronously force IDLE, counter=0, stage_en=0, stage_last=0, stage_id=0, busy=0, dataReady=0, unreachable=0.
REQ-016 Reset asserted mid-sequence SHALL abandon the sequence; the first start after release SHALL begin from T2D.

Configuration
REQ-017 With macro IK_REACH_CHECK_EN defined, cos_out_of_range SHALL be sampled on the COS stage_last cycle; if high, the next state SHALL be ERR instead of SIN.
REQ-018 Without IK_REACH_CHECK_EN, cos_out_of_range SHALL be ignored, ERR SHALL be unreachable, and unreachable SHALL be tied to 0.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
  Defaults; enable pulse at cycle 10 -> T2D cycles 11-16, COS cycles 17-30, ..., TH cycles 134-147, dataReady only at cycle 148.
  enable held high continuously -> dataReady pulses every 139 cycles; no stage overlap.
  abort in SIN, 5th cycle -> IDLE next cycle; stage_en=0; no dataReady.
  enable and abort both high in IDLE -> remains IDLE; busy stays 0.
  reset low during ATAN -> all outputs 0 immediately; new enable after release -> full 137-cycle sequence.
  IK_REACH_CHECK_EN defined, cos_out_of_range=1 at COS stage_last -> ERR, unreachable pulse, SIN bit never set; without the macro -> normal dataReady.
